// File: rtl/imem_if.sv
// Instruction-fetch request/response bundle between the IF stage (master)
// and the instruction memory responder (slave).
interface imem_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [63:0] rsp_addr;
   logic        rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
   );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: one read stage feeding a small response FIFO,
// with flush and a preload port. Define IMEM_ERR_EN to enable access-fault reporting.
module imem_responder #(
   parameter logic [63:0] BASE_ADDR      = 64'h8000_0000,
   parameter int          DEPTH_WORDS    = 1024,
   parameter int          RSP_FIFO_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           flush,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data,
   imem_if.slave                          bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(RSP_FIFO_DEPTH + 2);

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic          addr_err;
   logic          accept;
   logic          pop;
   logic [CW-1:0] occ;

   logic          vld_p1;
   logic [31:0]   data_p1;
   logic [63:0]   addr_p1;
   logic          err_p1;

   logic [31:0]   fifo_data [RSP_FIFO_DEPTH];
   logic [63:0]   fifo_addr [RSP_FIFO_DEPTH];
   logic          fifo_err  [RSP_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx = AW'((bus.req_addr - BASE_ADDR) >> 2);

`ifdef IMEM_ERR_EN
   assign addr_err = (bus.req_addr[1:0] != 2'b00) ||
                     (bus.req_addr < BASE_ADDR) ||
                     (bus.req_addr >= BASE_ADDR + (64'(DEPTH_WORDS) << 2));
`else
   assign addr_err = 1'b0;
`endif

   // Credits cover the read stage plus every FIFO slot, so a push never overflows.
   assign occ           = CW'(vld_p1) + count;
   assign pop           = bus.rsp_valid && bus.rsp_ready;
   assign bus.req_ready = resetn && !flush && ((occ - CW'(pop)) < CW'(RSP_FIFO_DEPTH));
   assign accept        = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk) begin
      if (ld_we) mem[ld_addr] <= ld_data;
   end

   // stage p1: array read, address echo and fault flag
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) vld_p1 <= 1'b0;
      else         vld_p1 <= accept;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_p1 <= addr_err ? 32'h0 : mem[idx];
         addr_p1 <= bus.req_addr;
         err_p1  <= addr_err;
      end
   end

   // stage p2: response FIFO, head drives the response port
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (vld_p1) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)    rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(vld_p1) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (vld_p1) begin
         fifo_data[wr_ptr] <= data_p1;
         fifo_addr[wr_ptr] <= addr_p1;
         fifo_err[wr_ptr]  <= err_p1;
      end
   end

   assign bus.rsp_valid = (count != '0);
   assign bus.rsp_data  = bus.rsp_valid ? fifo_data[rd_ptr] : 32'h0;
   assign bus.rsp_addr  = bus.rsp_valid ? fifo_addr[rd_ptr] : 64'h0;
   assign bus.rsp_err   = bus.rsp_valid ? fifo_err[rd_ptr]  : 1'b0;
endmodule
